// File: rtl/pia_input_cond.sv
// rtl/pia_input_cond.sv - joystick/console input conditioner producing SWCHA/SWCHB
module pia_input_cond #(
    parameter int TICK_DIV = 1000,
    parameter int DB_TICKS = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] joy_i,
    input  logic [4:0] con_i,
    output logic [7:0] swcha_o,
    output logic [7:0] swchb_o,
    output logic       changed_o
);
    localparam int NB = 13;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (DB_TICKS > 0) ? $clog2(DB_TICKS + 1) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

    logic [NB-1:0]         sync1;
    logic [NB-1:0]         sync2;
    logic [PW-1:0]         pre;
    logic                  tick;
    logic [NB-1:0]         db;
    logic [NB-1:0]         db_nxt;
    logic [NB-1:0][CW-1:0] cnt;
    logic [NB-1:0][CW-1:0] cnt_nxt;
    logic [2:0]            tog_prev;
    logic [2:0]            rise;
    logic                  colour;
    logic                  diff0;
    logic                  diff1;
    logic                  colour_nxt;
    logic                  diff0_nxt;
    logic                  diff1_nxt;
    logic [7:0]            joy_clean;
    logic [7:0]            swcha_nxt;
    logic [7:0]            swchb_nxt;

    // Nibble is {right, left, down, up}; opposing pairs pressed together cancel.
    function automatic logic [3:0] socd(input logic [3:0] n);
        logic [3:0] r;
        r = n;
        if (n[3] && n[2]) r[3:2] = 2'b00;
        if (n[1] && n[0]) r[1:0] = 2'b00;
        return r;
    endfunction

    assign tick = (pre == PRE_LAST);

    always_comb begin
        db_nxt  = db;
        cnt_nxt = cnt;
        if (tick) begin
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt_nxt[i] = '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db_nxt[i]  = sync2[i];
                    cnt_nxt[i] = '0;
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Toggle buttons act on the press edge of their debounced level only.
    always_comb begin
        rise       = db[12:10] & ~tog_prev;
        colour_nxt = colour ^ rise[0];
        diff0_nxt  = diff0 ^ rise[1];
        diff1_nxt  = diff1 ^ rise[2];
        joy_clean  = {socd(db[7:4]), socd(db[3:0])};
        swcha_nxt  = ~joy_clean;
        swchb_nxt  = {diff1_nxt, diff0_nxt, 2'b11, colour_nxt, 1'b1, ~db[9], ~db[8]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1     <= '0;
            sync2     <= '0;
            pre       <= '0;
            db        <= '0;
            cnt       <= '0;
            tog_prev  <= '0;
            colour    <= 1'b1;
            diff0     <= 1'b0;
            diff1     <= 1'b0;
            swcha_o   <= 8'hFF;
            swchb_o   <= 8'h3F;
            changed_o <= 1'b0;
        end else begin
            sync1     <= {con_i, joy_i};
            sync2     <= sync1;
            pre       <= tick ? '0 : pre + PW'(1);
            db        <= db_nxt;
            cnt       <= cnt_nxt;
            tog_prev  <= db[12:10];
            colour    <= colour_nxt;
            diff0     <= diff0_nxt;
            diff1     <= diff1_nxt;
            swcha_o   <= swcha_nxt;
            swchb_o   <= swchb_nxt;
            changed_o <= ({swcha_nxt, swchb_nxt} != {swcha_o, swchb_o});
        end
    end
endmodule

// File: tb/tb_pia_input_cond.sv
// tb/tb_pia_input_cond.sv - self-checking bench for pia_input_cond
module tb_pia_input_cond;
    localparam int TD = 4;
    localparam int DB = 3;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] joy_i;
    logic [4:0] con_i;
    logic [7:0] swcha_o;
    logic [7:0] swchb_o;
    logic       changed_o;

    always #5 clk_i = ~clk_i;

    pia_input_cond #(.TICK_DIV(TD), .DB_TICKS(DB)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .joy_i    (joy_i),
        .con_i    (con_i),
        .swcha_o  (swcha_o),
        .swchb_o  (swchb_o),
        .changed_o(changed_o)
    );

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Reference model state
    logic [12:0] pipe[$];
    int          m_cyc;
    logic [12:0] m_db;
    int          m_run[13];
    logic [2:0]  m_seen;
    logic [2:0]  m_flag;
    logic [7:0]  m_a;
    logic [7:0]  m_b;
    logic        m_chg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] socd_ref(input logic [3:0] n);
        logic [1:0] h;
        logic [1:0] v;
        h = n[3:2];
        v = n[1:0];
        return {(h == 2'b11) ? 2'b00 : h, (v == 2'b11) ? 2'b00 : v};
    endfunction

    task automatic model_edge(input logic r, input logic [12:0] raw);
        logic [12:0] s;
        logic [7:0]  a;
        logic [7:0]  b;
        if (r) begin
            pipe = '{13'h0, 13'h0};
            m_cyc = 0;
            m_db = '0;
            for (int i = 0; i < 13; i++) m_run[i] = 0;
            m_seen = '0;
            m_flag = 3'b001;
            m_a = 8'hFF;
            m_b = 8'h3F;
            m_chg = 1'b0;
        end else begin
            for (int k = 0; k < 3; k++)
                if (m_db[10+k] && !m_seen[k]) m_flag[k] = !m_flag[k];
            m_seen = m_db[12:10];
            a = ~{socd_ref(m_db[7:4]), socd_ref(m_db[3:0])};
            b = {m_flag[2], m_flag[1], 2'b11, m_flag[0], 1'b1, ~m_db[9], ~m_db[8]};
            m_chg = ({a, b} != {m_a, m_b});
            m_a = a;
            m_b = b;
            s = pipe[0];
            if (m_cyc % TD == TD - 1) begin
                for (int i = 0; i < 13; i++) begin
                    if (s[i] == m_db[i]) begin
                        m_run[i] = 0;
                    end else begin
                        m_run[i]++;
                        if (m_run[i] == DB) begin
                            m_db[i] = s[i];
                            m_run[i] = 0;
                        end
                    end
                end
            end
            m_cyc++;
            void'(pipe.pop_front());
            pipe.push_back(raw);
        end
    endtask

    task automatic step(input logic [7:0] j, input logic [4:0] c, input logic r);
        joy_i = j;
        con_i = c;
        rst_i = r;
        @(posedge clk_i);
        model_edge(r, {c, j});
        #1;
        chk("swcha", swcha_o, m_a);
        chk("swchb", swchb_o, m_b);
        chk("changed", changed_o, m_chg);
        if (changed_o === 1'b1) pulses++;
    endtask

    task automatic hold(input logic [7:0] j, input logic [4:0] c, input int n);
        for (int i = 0; i < n; i++) step(j, c, 1'b0);
    endtask

    initial begin
        int lat;
        logic bad;
        logic [7:0] rj;
        logic [4:0] rc;
        int left;

        rst_i = 1'b1;
        joy_i = 8'($urandom);
        con_i = 5'($urandom);
        step(8'($urandom), 5'($urandom), 1'b1);
        step(8'($urandom), 5'($urandom), 1'b1);
        chk("rst_swcha", swcha_o, 8'hFF);
        chk("rst_swchb", swchb_o, 8'h3F);
        chk("rst_changed", changed_o, 1'b0);
        pulses = 0;
        hold(8'h00, 5'h00, 3 * TD);
        chk("rst_hold_pulses", pulses, 0);

        // Debounce accept
        pulses = 0;
        lat = 0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            step(8'h80, 5'h00, 1'b0);
            if (swcha_o === 8'h7F) lat = n;
        end
        hold(8'h80, 5'h00, 5);
        chk("acc_lat_min", lat >= 2 + TD * (DB - 1) + 2, 1'b1);
        chk("acc_lat_max", lat != 0 && lat <= 2 + TD * DB + 1, 1'b1);
        chk("acc_pulses", pulses, 1);
        hold(8'h00, 5'h00, 20);

        // Glitch reject
        pulses = 0;
        bad = 1'b0;
        for (int n = 0; n < 28; n++) begin
            step((n < 8) ? 8'h10 : 8'h00, 5'h00, 1'b0);
            if (swcha_o !== 8'hFF) bad = 1'b1;
        end
        chk("glitch_hold", bad, 1'b0);
        chk("glitch_pulses", pulses, 0);

        // Opposing directions
        hold(8'hC0, 5'h00, 20);
        chk("socd_both", swcha_o, 8'hFF);
        hold(8'h40, 5'h00, 20);
        chk("socd_left", swcha_o, 8'hBF);
        hold(8'h00, 5'h00, 20);

        // Toggles
        hold(8'h00, 5'h04, 20);
        hold(8'h00, 5'h00, 20);
        chk("tog_colour_off", swchb_o, 8'h37);
        hold(8'h00, 5'h04, 20);
        hold(8'h00, 5'h00, 20);
        chk("tog_colour_on", swchb_o, 8'h3F);
        hold(8'h00, 5'h08, 20);
        chk("tog_diff0", swchb_o, 8'h7F);
        pulses = 0;
        hold(8'h00, 5'h08, 30);
        chk("tog_held_pulses", pulses, 0);
        chk("tog_held_val", swchb_o, 8'h7F);

        // Reset mid-debounce
        hold(8'h80, 5'h08, 2 + TD);
        step(8'h80, 5'h08, 1'b1);
        chk("mid_rst_swcha", swcha_o, 8'hFF);
        chk("mid_rst_swchb", swchb_o, 8'h3F);
        chk("mid_rst_changed", changed_o, 1'b0);
        lat = 0;
        for (int n = 1; n <= 30 && lat == 0; n++) begin
            step(8'h80, 5'h00, 1'b0);
            if (swcha_o === 8'h7F) lat = n;
        end
        chk("mid_rst_restart", lat, TD * DB + 1);
        hold(8'h00, 5'h00, 20);

        // Randomized run against the model
        rj = '0;
        rc = '0;
        left = 0;
        for (int n = 0; n < 2500; n++) begin
            if (left == 0) begin
                rj = 8'($urandom);
                rc = 5'($urandom);
                left = $urandom_range(1, 40);
            end
            left--;
            step(rj, rc, ($urandom_range(0, 299) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
